// File: rtl/spdif_pkg.sv
// rtl/spdif_pkg.sv - shared state encodings, source IDs and error-token value for the S/PDIF source arbiter.
package spdif_pkg;

   typedef enum logic [1:0] {
      EXP_L = 2'd0,
      EXP_R = 2'd1,
      ERR   = 2'd2
   } state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam int ERR_AUDIO = 0;

endpackage

// File: rtl/spdif_watchdog_timer.sv
// rtl/spdif_watchdog_timer.sv - saturating idle counter; expired is high once timeout-1 cycles have passed without a clear.
module spdif_watchdog_timer #(
   parameter int timeout = 512
) (
   input  logic clk256,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int cw = $clog2(timeout);
   localparam logic [cw-1:0] last = cw'(timeout - 1);

   logic [cw-1:0] count;

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && count != last)
         count <= count + cw'(1);
   end

   assign expired = (count == last);

endmodule

// File: rtl/spdif_source_arbiter.sv
// rtl/spdif_source_arbiter.sv - selects source A or B on stereo-pair boundaries into one output slot.
// Watchdog error tokens exist only with SPDIF_ARB_WATCHDOG_EN defined.
module spdif_source_arbiter
   import spdif_pkg::*;
#(
   parameter int audio_width = 16,
   parameter int timeout     = 512
) (
   input  logic                   reset,
   input  logic                   clk256,
   input  logic                   i_sel,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic [audio_width-1:0] a_audio,
   input  logic                   a_is_left,
   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic [audio_width-1:0] b_audio,
   input  logic                   b_is_left,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [audio_width-1:0] o_audio,
   output logic                   o_is_left,
   output logic                   o_is_error,
   output logic                   o_active_src
);

   state_t                 state;
   state_t                 state_nxt;
   logic                   slot_free;
   logic                   act_valid;
   logic                   act_ready;
   logic                   act_xfer;
   logic                   act_is_left;
   logic [audio_width-1:0] act_audio;
   logic                   load_data;
   logic                   load_token;
   logic                   switch_ok;
   logic                   expired;

   // The inactive source is always drained so it never stalls upstream.
   always_comb begin
      slot_free   = ~o_valid | o_ready;
      act_ready   = (state != ERR) & slot_free & ~reset;
      act_valid   = (o_active_src == SRC_B) ? b_valid   : a_valid;
      act_audio   = (o_active_src == SRC_B) ? b_audio   : a_audio;
      act_is_left = (o_active_src == SRC_B) ? b_is_left : a_is_left;
      a_ready     = (o_active_src == SRC_B) ? ~reset    : act_ready;
      b_ready     = (o_active_src == SRC_B) ? act_ready : ~reset;
      act_xfer    = act_valid & act_ready;
   end

   always_comb begin
      state_nxt  = state;
      load_data  = 1'b0;
      load_token = 1'b0;
      switch_ok  = 1'b0;
      case (state)
         EXP_L: begin
            switch_ok = ~act_xfer;
            if (act_xfer) begin
               if (act_is_left) begin
                  load_data = 1'b1;
                  state_nxt = EXP_R;
               end
            end else if (expired) begin
               state_nxt = ERR;
            end
         end
         EXP_R: begin
            if (act_xfer) begin
               if (!act_is_left) begin
                  load_data = 1'b1;
                  state_nxt = EXP_L;
               end
            end else if (expired) begin
               state_nxt = ERR;
            end
         end
`ifdef SPDIF_ARB_WATCHDOG_EN
         ERR: begin
            if (slot_free) begin
               load_token = 1'b1;
               state_nxt  = EXP_L;
            end
         end
`endif
         default: state_nxt = EXP_L;
      endcase
   end

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset)
         state <= EXP_L;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset)
         o_active_src <= SRC_A;
      else if (switch_ok)
         o_active_src <= i_sel;
   end

   always_ff @(posedge clk256 or posedge reset) begin
      if (reset) begin
         o_valid   <= 1'b0;
         o_audio   <= '0;
         o_is_left <= 1'b0;
      end else if (load_data) begin
         o_valid   <= 1'b1;
         o_audio   <= act_audio;
         o_is_left <= act_is_left;
      end else if (load_token) begin
         o_valid   <= 1'b1;
         o_audio   <= audio_width'(ERR_AUDIO);
         o_is_left <= 1'b1;
      end else if (o_ready) begin
         o_valid   <= 1'b0;
      end
   end

`ifdef SPDIF_ARB_WATCHDOG_EN
   always_ff @(posedge clk256 or posedge reset) begin
      if (reset)
         o_is_error <= 1'b0;
      else if (load_data)
         o_is_error <= 1'b0;
      else if (load_token)
         o_is_error <= 1'b1;
   end

   spdif_watchdog_timer #(
      .timeout (timeout)
   ) u_watchdog (
      .clk256  (clk256),
      .reset   (reset),
      .clear   (act_xfer | load_token),
      .enable  (1'b1),
      .expired (expired)
   );
`else
   assign o_is_error = 1'b0;
   assign expired    = 1'b0;
`endif

endmodule

// File: tb/tb_spdif_source_arbiter.sv
// tb/tb_spdif_source_arbiter.sv - directed scoreboard bench for spdif_source_arbiter.
module tb_spdif_source_arbiter;

   logic        clk256 = 1'b0;
   logic        reset = 1'b1;
   logic        i_sel = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [15:0] a_audio = '0;
   logic        a_is_left = 1'b0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [15:0] b_audio = '0;
   logic        b_is_left = 1'b0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [15:0] o_audio;
   logic        o_is_left;
   logic        o_is_error;
   logic        o_active_src;

   int checks = 0;
   int errors = 0;
   int tok_seen = 0;
   int tok_exp1;
   int tok_exp2;
   logic [17:0] q[$];
   logic [17:0] exp_item;
   logic        ok;

   spdif_source_arbiter #(.audio_width(16), .timeout(512)) dut (
      .reset        (reset),
      .clk256       (clk256),
      .i_sel        (i_sel),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_audio      (a_audio),
      .a_is_left    (a_is_left),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_audio      (b_audio),
      .b_is_left    (b_is_left),
      .o_valid      (o_valid),
      .o_ready      (o_ready),
      .o_audio      (o_audio),
      .o_is_left    (o_is_left),
      .o_is_error   (o_is_error),
      .o_active_src (o_active_src)
   );

   always #5 clk256 = ~clk256;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, expv);
      end
   endtask

   // Output monitor: every output transfer is popped from the scoreboard.
   always @(negedge clk256) begin
      if (!reset && o_valid && o_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output got %h expected none", {o_audio, o_is_left, o_is_error});
         end
         if (q.size() != 0) begin
            exp_item = q.pop_front();
            checks++;
            assert ({o_audio, o_is_left, o_is_error} === exp_item) else begin
               errors++;
               $error("FAIL out_data got %h expected %h", {o_audio, o_is_left, o_is_error}, exp_item);
            end
         end
         if (o_is_error) tok_seen++;
      end
   end

   task automatic send(input bit src, input logic [15:0] d, input bit l, input bit fwd);
      @(posedge clk256); #1;
      if (src) begin b_valid = 1'b1; b_audio = d; b_is_left = l; end
      else     begin a_valid = 1'b1; a_audio = d; a_is_left = l; end
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk256);
         ok = src ? b_ready : a_ready;
      end
      check("send_accept", {31'd0, ok}, 32'd1);
      if (fwd) q.push_back({d, l, 1'b0});
      @(posedge clk256); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   initial begin
`ifdef SPDIF_ARB_WATCHDOG_EN
      tok_exp1 = 1;
      tok_exp2 = 2;
`else
      tok_exp1 = 0;
      tok_exp2 = 0;
`endif
      repeat (3) @(posedge clk256);
      @(negedge clk256);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_audio", o_audio, 0);
      check("rst_o_is_left", o_is_left, 0);
      check("rst_o_is_error", o_is_error, 0);
      check("rst_active_src", o_active_src, 0);
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      @(posedge clk256); #1;
      reset = 1'b0;
      o_ready = 1'b1;
      @(negedge clk256);
      check("idle_a_ready", a_ready, 1);
      check("idle_b_ready", b_ready, 1);

      // Pair through A with one-cycle latency.
      send(0, 16'h1234, 1, 1);
      @(negedge clk256);
      check("lat_l_valid", o_valid, 1);
      check("lat_l_audio", {o_audio, o_is_left}, {16'h1234, 1'b1});
      send(0, 16'h5678, 0, 1);
      @(negedge clk256);
      check("lat_r_valid", o_valid, 1);
      check("lat_r_audio", {o_audio, o_is_left}, {16'h5678, 1'b0});
      check("pair_b_ready", b_ready, 1);

      // Switch requested mid-pair.
      send(0, 16'h1111, 1, 1);
      i_sel = 1'b1;
      @(negedge clk256);
      check("midpair_src_held", o_active_src, 0);
      send(0, 16'h2222, 0, 1);
      @(negedge clk256);
      check("switch_not_yet", o_active_src, 0);
      @(negedge clk256);
      check("switch_done", o_active_src, 1);
      check("drain_a_ready", a_ready, 1);
      send(0, 16'h9999, 1, 0);
      send(1, 16'h3333, 1, 1);
      send(1, 16'h4444, 0, 1);

      // Misaligned start: leading right sample dropped.
      send(1, 16'h0001, 0, 0);
      send(1, 16'h0002, 1, 1);
      send(1, 16'h0003, 0, 1);

      // Backpressure.
      @(posedge clk256); #1;
      o_ready = 1'b0;
      send(1, 16'h0010, 1, 1);
      b_valid = 1'b1; b_audio = 16'h0011; b_is_left = 1'b0;
      q.push_back({16'h0011, 1'b0, 1'b0});
      repeat (10) begin
         @(negedge clk256);
         check("bp_ready_low", b_ready, 0);
         check("bp_hold", {o_valid, o_audio, o_is_left}, {1'b1, 16'h0010, 1'b1});
      end
      @(posedge clk256); #1;
      o_ready = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk256);
         ok = b_ready;
      end
      check("bp_resume", {31'd0, ok}, 32'd1);
      @(posedge clk256); #1;
      b_valid = 1'b0;
      send(1, 16'h0012, 1, 1);
      send(1, 16'h0013, 0, 1);

      // Reset with a pending output slot.
      @(posedge clk256); #1;
      o_ready = 1'b0;
      send(1, 16'h0020, 1, 0);
      @(negedge clk256);
      check("pre_rst_valid", o_valid, 1);
      #2;
      reset = 1'b1;
      i_sel = 1'b0;
      #1;
      check("async_rst_valid", o_valid, 0);
      check("async_rst_a_ready", a_ready, 0);
      check("async_rst_b_ready", b_ready, 0);
      check("async_rst_src", o_active_src, 0);
      @(posedge clk256); #1;
      reset = 1'b0;
      o_ready = 1'b1;
      send(0, 16'h0021, 0, 0);
      send(0, 16'h0022, 1, 1);
      send(0, 16'h0023, 0, 1);

      // Watchdog: idle inputs.
      if (tok_exp2 != 0) begin
         q.push_back({16'h0000, 1'b1, 1'b1});
         q.push_back({16'h0000, 1'b1, 1'b1});
      end
      repeat (500) @(posedge clk256);
      @(negedge clk256);
      check("wd_none_early", tok_seen, 0);
      repeat (30) @(posedge clk256);
      @(negedge clk256);
      check("wd_first", tok_seen, tok_exp1);
      repeat (470) @(posedge clk256);
      @(negedge clk256);
      check("wd_no_repeat", tok_seen, tok_exp1);
      repeat (60) @(posedge clk256);
      @(negedge clk256);
      check("wd_second", tok_seen, tok_exp2);

      check("scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
